// File: rtl/uart_pkg.sv
// Shared UART subsystem types and limits.
// Used by the TX arbiter and its round-robin picker.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } uart_arb_state_t;

   localparam int UART_ARB_MAX_REQ = 16;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority search over a valid vector.
// Returns the first set bit at or above rr_ptr, wrapping.
import uart_pkg::*;

module uart_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   winner,
   output logic [NUM_REQ-1:0] grant
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   // Walk offsets 0..NUM_REQ-1 from rr_ptr; first hit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [IDX_W:0] pos;
         pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (pos >= N_W) pos = pos - N_W;
         if (!found && valid[pos[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = pos[IDX_W-1:0];
         end
      end
   end

   // One-hot view of the winner, empty when nothing is valid.
   always_comb begin
      grant = '0;
      if (found) grant[winner] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between requesters.
// Optional CTS hold in LAUNCH: define UART_TX_ARBITER_CTS_EN.
import uart_pkg::*;

module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ*8-1:0] i_req_data,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic                 o_tx_start,
   output logic [7:0]           o_tx_word,
   input  logic                 i_tx_done,
`ifdef UART_TX_ARBITER_CTS_EN
   input  logic                 i_hw_flow_control_enable,
   input  logic                 i_cts_n,
`endif
   input  logic [31:0]          i_timeout,
   input  logic                 i_err_clr,
   output logic                 o_busy,
   output logic [IDX_W-1:0]     o_grant_id,
   output logic                 o_xfer_done,
   output logic                 o_timeout_err,
   output logic                 o_timeout_sticky
);

   uart_arb_state_t    state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [31:0]        wdog;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   next_ptr;
   logic               hold;
   logic               wd_on;
   logic               wd_exp;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid  (i_req_valid),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .winner (pick_idx),
      .grant  (pick_grant)
   );

`ifdef UART_TX_ARBITER_CTS_EN
   assign hold = i_hw_flow_control_enable & i_cts_n;
`else
   assign hold = 1'b0;
`endif

   assign wd_on  = (i_timeout != 32'd0);
   assign wd_exp = wd_on && (wdog <= 32'd1);

   assign next_ptr = (o_grant_id == IDX_W'(NUM_REQ-1))
                   ? '0 : o_grant_id + 1'b1;

   assign o_req_ready = (state == IDLE && i_nrst)
                      ? pick_grant : '0;
   assign o_tx_start  = (state == LAUNCH) && !hold;
   assign o_busy      = (state != IDLE);

   // Transfer sequencer: accept, launch, wait for done or watchdog.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         wdog             <= '0;
         o_tx_word        <= '0;
         o_grant_id       <= '0;
         o_xfer_done      <= 1'b0;
         o_timeout_err    <= 1'b0;
         o_timeout_sticky <= 1'b0;
      end else begin
         o_xfer_done   <= 1'b0;
         o_timeout_err <= 1'b0;
         if (i_err_clr) o_timeout_sticky <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_found) begin
                  o_tx_word  <= i_req_data[{pick_idx, 3'b000} +: 8];
                  o_grant_id <= pick_idx;
                  wdog       <= i_timeout;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (hold) begin
                  if (wd_exp) begin
                     o_timeout_err    <= 1'b1;
                     o_timeout_sticky <= 1'b1;
                     rr_ptr           <= next_ptr;
                     state            <= IDLE;
                  end else if (wd_on) begin
                     wdog <= wdog - 32'd1;
                  end
               end else begin
                  state <= WAIT_DONE;
                  if (wd_on && wdog != 32'd0) wdog <= wdog - 32'd1;
               end
            end
            WAIT_DONE: begin
               if (i_tx_done) begin
                  o_xfer_done <= 1'b1;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end else if (wd_exp) begin
                  o_timeout_err    <= 1'b1;
                  o_timeout_sticky <= 1'b1;
                  rr_ptr           <= next_ptr;
                  state            <= IDLE;
               end else if (wd_on) begin
                  wdog <= wdog - 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter.
// Covers CTS hold when UART_TX_ARBITER_CTS_EN is defined.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   typedef struct {
      logic [1:0] id;
      logic [7:0] word;
   } exp_t;

   logic         clk = 1'b0;
   logic         nrst;
   logic [N-1:0] req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0] req_ready;
   logic         tx_start;
   logic [7:0]   tx_word;
   logic         tx_done;
   logic [31:0]  timeout;
   logic         err_clr;
   logic         busy;
   logic [1:0]   grant_id;
   logic         xfer_done;
   logic         timeout_err;
   logic         sticky;
`ifdef UART_TX_ARBITER_CTS_EN
   logic         flow_en;
   logic         cts_n;
`endif

   exp_t sbq[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   uart_tx_arbiter #(.NUM_REQ(N)) dut (
      .i_clk            (clk),
      .i_nrst           (nrst),
      .i_req_valid      (req_valid),
      .i_req_data       (req_data),
      .o_req_ready      (req_ready),
      .o_tx_start       (tx_start),
      .o_tx_word        (tx_word),
      .i_tx_done        (tx_done),
`ifdef UART_TX_ARBITER_CTS_EN
      .i_hw_flow_control_enable (flow_en),
      .i_cts_n          (cts_n),
`endif
      .i_timeout        (timeout),
      .i_err_clr        (err_clr),
      .o_busy           (busy),
      .o_grant_id       (grant_id),
      .o_xfer_done      (xfer_done),
      .o_timeout_err    (timeout_err),
      .o_timeout_sticky (sticky)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop();
      exp_t e;
      chk("sb_nonempty", 32'(sbq.size() != 0), 1);
      if (sbq.size() == 0) return;
      e = sbq.pop_front();
      chk("sb_grant_id", 32'(grant_id), 32'(e.id));
      chk("sb_tx_word", 32'(tx_word), 32'(e.word));
   endtask

   task automatic wait_start(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (tx_start) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      chk(tag, 32'(ok), 1);
   endtask

   task automatic wait_err(input string tag, input int exp_lat);
      int lat;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         cyc();
         if (timeout_err) begin
            lat = i;
            break;
         end
      end
      chk(tag, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      bit bad;
      int prev;

      nrst      = 1'b0;
      req_valid = '1;
      req_data  = 32'h44A52211;
      tx_done   = 1'b0;
      timeout   = 32'd0;
      err_clr   = 1'b0;
`ifdef UART_TX_ARBITER_CTS_EN
      flow_en   = 1'b0;
      cts_n     = 1'b0;
`endif
      repeat (3) cyc();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_word", 32'(tx_word), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_flags", {29'd0, xfer_done, timeout_err, sticky}, 0);

      req_valid = '0;
      nrst = 1'b1;
      cyc();
      chk("idle_no_ready", 32'(req_ready), 0);

      // single request on ch2
      req_valid = 4'b0100;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0100);
      sbq.push_back('{2'd2, 8'hA5});
      cyc();
      req_valid = '0;
      #1;
      chk("single_start", 32'(tx_start), 1);
      sb_pop();
      chk("single_busy", 32'(busy), 1);
      chk("launch_no_ready", 32'(req_ready), 0);
      bad = 1'b0;
      for (int i = 0; i < 99; i++) begin
         cyc();
         if (tx_start || xfer_done || req_ready != 0 || tx_word != 8'hA5)
            bad = 1'b1;
      end
      chk("single_quiet", 32'(bad), 0);
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      chk("single_done", 32'(xfer_done), 1);
      chk("single_gid", 32'(grant_id), 2);
      chk("single_idle", 32'(busy), 0);
      cyc();
      chk("done_one_cycle", 32'(xfer_done), 0);

      // round robin with all channels valid
      nrst = 1'b0;
      cyc();
      nrst = 1'b1;
      cyc();
      req_data = 32'h13121110;
      for (int k = 0; k < 6; k++)
         sbq.push_back('{2'(k % 4), 8'h10 + 8'(k % 4)});
      req_valid = '1;
      prev = -1;
      bad = 1'b0;
      for (int t = 0; t < 6; t++) begin
         wait_start("rr_start");
         chk("rr_no_repeat", 32'(int'(grant_id) != prev), 1);
         prev = int'(grant_id);
         sb_pop();
         for (int i = 0; i < 10; i++) begin
            cyc();
            if (req_ready != 0) bad = 1'b1;
         end
         tx_done = 1'b1;
         cyc();
         tx_done = 1'b0;
         chk("rr_done", 32'(xfer_done), 1);
      end
      req_valid = '0;
      chk("rr_ready_only_idle", 32'(bad), 0);

      // watchdog abort, sticky, clear, next channel
      timeout = 32'd50;
      req_data = 32'h335C3130;
      req_valid = 4'b0100;
      sbq.push_back('{2'd2, 8'h5C});
      wait_start("to_start");
      req_valid = '0;
      sb_pop();
      wait_err("to_latency", 50);
      chk("to_sticky", 32'(sticky), 1);
      chk("to_no_done", 32'(xfer_done), 0);
      chk("to_idle", 32'(busy), 0);
      repeat (5) cyc();
      chk("to_sticky_hold", 32'(sticky), 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("to_clear", 32'(sticky), 0);
      req_valid = '1;
      sbq.push_back('{2'd3, 8'h33});
      wait_start("to_next_start");
      req_valid = '0;
      sb_pop();
      err_clr = 1'b1;
      wait_err("to_latency2", 50);
      chk("set_wins", 32'(sticky), 1);
      cyc();
      chk("clr_after", 32'(sticky), 0);
      err_clr = 1'b0;

      // done on the watchdog expiry cycle
      timeout = 32'd20;
      req_data = 32'h335C313C;
      req_valid = 4'b0001;
      sbq.push_back('{2'd0, 8'h3C});
      wait_start("exp_start");
      req_valid = '0;
      sb_pop();
      repeat (19) cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      chk("exp_done", 32'(xfer_done), 1);
      chk("exp_no_err", 32'(timeout_err), 0);
      chk("exp_sticky", 32'(sticky), 0);
      cyc();
      chk("exp_no_err2", 32'(timeout_err), 0);
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      chk("idle_done_ignored", 32'(xfer_done), 0);
      chk("idle_done_busy", 32'(busy), 0);

      // reset during WAIT_DONE
      req_valid = 4'b0100;
      sbq.push_back('{2'd2, 8'h5C});
      wait_start("mid_start");
      req_valid = '0;
      sb_pop();
      repeat (5) cyc();
      chk("mid_busy", 32'(busy), 1);
      nrst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_word", 32'(tx_word), 0);
      chk("mid_rst_grant", 32'(grant_id), 0);
      chk("mid_rst_start", 32'(tx_start), 0);
      cyc();
      nrst = 1'b1;
      req_valid = '1;
      #1;
      chk("mid_rr_reset", 32'(req_ready), 32'b0001);
      sbq.push_back('{2'd0, 8'h3C});
      wait_start("mid_next_start");
      req_valid = '0;
      sb_pop();
      repeat (3) cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      chk("mid_next_done", 32'(xfer_done), 1);

`ifdef UART_TX_ARBITER_CTS_EN
      // CTS hold in LAUNCH
      timeout = 32'd0;
      flow_en = 1'b1;
      cts_n = 1'b1;
      req_valid = 4'b0010;
      sbq.push_back('{2'd1, 8'h31});
      cyc();
      req_valid = '0;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx_start || !busy) bad = 1'b1;
         cyc();
      end
      chk("cts_hold", 32'(bad), 0);
      cts_n = 1'b0;
      #1;
      chk("cts_start", 32'(tx_start), 1);
      sb_pop();
      cyc();
      chk("cts_start_once", 32'(tx_start), 0);
      repeat (2) cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      chk("cts_done", 32'(xfer_done), 1);
      timeout = 32'd10;
      cts_n = 1'b1;
      req_valid = 4'b0100;
      cyc();
      req_valid = '0;
      wait_err("cts_abort", 10);
      chk("cts_abort_sticky", 32'(sticky), 1);
      flow_en = 1'b0;
      cts_n = 1'b0;
`endif

      chk("sb_drained", 32'(sbq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx transmitter between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte at a time from the winning requester and sequences the transmitter: start pulse, then wait for done.
- Guards each transfer with a programmable timeout watchdog.
- Sits between the register/FIFO front-ends and the uart_tx core. It is the TX-side peer of uart_rx in the UART subsystem.

Parameters:
- NUM_REQ, 4, number of requester channels (2..16).
- IDX_W, $clog2(NUM_REQ), width of grant index (derived; do not override).

Ports:
- i_clk  input  1  system clock.
- i_nrst  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester byte-valid.
- i_req_data  input  NUM_REQ*8  per-requester byte; channel k occupies bits [8k+7:8k].
- o_req_ready  output  NUM_REQ  one-hot accept strobe.
- o_tx_start  output  1  one-cycle start pulse to uart_tx.
- o_tx_word  output  8  byte presented to uart_tx; stable from start until done.
- i_tx_done  input  1  uart_tx transfer-complete pulse.
- i_timeout  input  32  watchdog limit in clock cycles; 0 = watchdog disabled.
- i_err_clr  input  1  clears o_timeout_sticky.
- o_busy  output  1  high in any state except IDLE.
- o_grant_id  output  IDX_W  index of the channel being served.
- o_xfer_done  output  1  one-cycle pulse on successful completion.
- o_timeout_err  output  1  one-cycle pulse on watchdog abort.
- o_timeout_sticky  output  1  latched timeout flag.

Behaviour:
- Reset values: every output 0; rr_ptr = 0; watchdog = 0; state = IDLE.
- State machine: IDLE -> LAUNCH -> WAIT_DONE -> IDLE.
- IDLE:
  - Winner = first asserted i_req_valid bit, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - o_req_ready[winner] is asserted combinationally in the same cycle; the handshake completes that cycle.
  - On the clock edge: capture the winner's byte into o_tx_word, set o_grant_id = winner, go to LAUNCH.
  - With no valid asserted: stay in IDLE, no ready asserted.
- LAUNCH:
  - o_tx_start = 1 for exactly one cycle; watchdog loaded with i_timeout; go to WAIT_DONE.
- WAIT_DONE:
  - i_tx_done -> o_xfer_done pulse next cycle; rr_ptr = grant+1 (wraps NUM_REQ-1 -> 0); go to IDLE.
  - Otherwise, if i_timeout != 0: watchdog decrements each cycle. Reaching 1 without done -> o_timeout_err pulse, o_timeout_sticky set, rr_ptr advances as on done, go to IDLE.
- Latency: valid (while IDLE) to o_tx_start = 1 cycle. Back-to-back transfers cost 1 IDLE cycle between done and the next accept.
- Boundaries and priorities:
  - i_tx_done and watchdog expiry in the same cycle: done wins; no error is raised.
  - i_tx_done seen in IDLE or LAUNCH: ignored.
  - o_req_ready is never asserted outside IDLE.
  - Requesters must hold valid and data until ready. Dropping valid early is legal; that channel is simply not granted.
  - i_err_clr and a new timeout in the same cycle: the set wins.
  - Reset mid-transfer: immediate return to IDLE, all outputs 0, rr_ptr = 0. The captured byte is lost.
  - rr_ptr arithmetic is modulo NUM_REQ, including non-power-of-two NUM_REQ.

Optional Feature:
- Macro: UART_TX_ARBITER_CTS_EN.
- Defined:
  - Adds ports i_hw_flow_control_enable (input, 1) and i_cts_n (input, 1).
  - LAUNCH holds with o_tx_start = 0 while i_hw_flow_control_enable && i_cts_n. It pulses start on the first cycle CTS is low.
  - The watchdog runs during this hold, loaded on entry to LAUNCH.
- Undefined: ports absent; LAUNCH always lasts 1 cycle.

Decomposition:
- uart_pkg gains:
  - typedef enum logic [1:0] uart_arb_state_t {IDLE, LAUNCH, WAIT_DONE}.
  - localparam UART_ARB_MAX_REQ = 16.
- Sub-module uart_rr_picker: combinational rotate-priority search.
  - Inputs: valid vector, rr_ptr.
  - Outputs: found flag, winner index, one-hot grant.
  - Reusable by a future RX dispatch block.

Test Plan:
- Single request, ch2 valid with 0xA5, i_timeout=0 -> ready[2] one cycle; tx_start next cycle with o_tx_word=0xA5; done after 100 cycles -> o_xfer_done pulse, o_grant_id=2.
- All four channels valid continuously, tx_done 10 cycles after each start -> grants in order 0,1,2,3,0,1; no channel granted twice in a row.
- i_timeout=50 with tx_done never asserted -> o_timeout_err pulse 50 cycles after start; sticky=1 until i_err_clr; next grant goes to the following channel.
- i_timeout=20 with tx_done on the expiry cycle -> o_xfer_done=1, o_timeout_err=0, sticky stays 0.
- Reset asserted during WAIT_DONE -> all outputs 0 immediately; after release, ch0 is granted first.
- (CTS_EN) flow enable=1, i_cts_n high for 30 cycles -> no tx_start until the cycle i_cts_n falls; timeout=10 -> abort while held.
